// File: rtl/sort_out_serializer_if.sv
// Bus bundle between the sorter, the output serializer and the downstream consumer.
// The master modport is the environment side: it supplies the frame strobe and
// the consumer's ready. The slave modport is the serializer itself.
interface sort_out_serializer_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int IW = $clog2(W);

    logic                  i_vld;
    logic [W-1:0][N-1:0]   i_y;
    logic                  o_rdy;
    logic [N-1:0]          o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [IW-1:0]         o_idx;
    logic                  o_last;
    logic                  o_drop;
    logic [7:0]            o_drop_cnt;

    modport master (
        output i_vld, i_y, i_ready,
        input  o_rdy, o_data, o_valid, o_idx, o_last, o_drop, o_drop_cnt
    );

    modport slave (
        input  i_vld, i_y, i_ready,
        output o_rdy, o_data, o_valid, o_idx, o_last, o_drop, o_drop_cnt
    );
endinterface

// File: rtl/sort_out_serializer.sv
// Serializes sorted frames element by element (index 0 first) over valid/ready.
// An active frame drains while one pending frame may wait behind it; frames
// arriving with both slots occupied are dropped and counted (saturating).
module sort_out_serializer #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sort_out_serializer_if.slave    bus
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LastIdx = IW'(W - 1);

    // EMPTY: no active frame; ACTIVE: active only; FULL: active plus pending.
    typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

    state_e              state_q, state_d;
    logic [W-1:0][N-1:0] act_q, act_d;
    logic [W-1:0][N-1:0] pend_q, pend_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                drop_q;
    logic [7:0]          drop_cnt_q;

    logic rdy;
    logic valid;
    logic accept;
    logic drop;
    logic xfer;
    logic last_xfer;

    // Handshake decode; rdy depends on registered state only.
    always_comb begin
        rdy       = (state_q != StFull);
        valid     = (state_q != StEmpty);
        accept    = bus.i_vld && rdy;
        drop      = bus.i_vld && !rdy;
        xfer      = valid && bus.i_ready;
        last_xfer = xfer && (idx_q == LastIdx);
    end

    // Next-state and datapath selection for the two-slot frame buffer.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        idx_d   = xfer ? idx_q + IW'(1) : idx_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    act_d   = bus.i_y;
                    idx_d   = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (last_xfer) begin
                    idx_d = '0;
                    if (accept) begin
                        // New frame slides straight into the active slot, no bubble.
                        act_d = bus.i_y;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (accept) begin
                    pend_d  = bus.i_y;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (last_xfer) begin
                    act_d   = pend_q;
                    idx_d   = '0;
                    state_d = StActive;
                end
            end
            default: begin
                state_d = StEmpty;
                idx_d   = '0;
            end
        endcase
    end

    // Frame buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            act_q   <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
        end
    end

    // Registered drop pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            drop_q <= drop;
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign bus.o_rdy      = rdy;
    assign bus.o_valid    = valid;
    assign bus.o_data     = act_q[idx_q];
    assign bus.o_idx      = idx_q;
    assign bus.o_last     = valid && (idx_q == LastIdx);
    assign bus.o_drop     = drop_q;
    assign bus.o_drop_cnt = drop_cnt_q;
endmodule
